// File: rtl/mod_up_down_counter.sv
// rtl/mod_up_down_counter.sv - modulo up/down counter with wrap, saturate, one-shot and hold modes
// Sticky ovf, registered done; rco_b is combinational for cascading.
module mod_up_down_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         en_b,
  input  logic         load_b,
  input  logic         up,
  input  logic [1:0]   mode,
  input  logic [N-1:0] step,
  input  logic [N-1:0] mod_max,
  input  logic [N-1:0] load_in,
  output logic [N-1:0] q,
  output logic         rco_b,
  output logic         ovf,
  output logic         done
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [1:0] M_WRAP = 2'b00;
  localparam logic [1:0] M_ONE  = 2'b10;
  localparam logic [1:0] M_HOLD = 2'b11;

  state_t       state, state_nx;
  logic [N-1:0] q_nx;
  logic         ovf_nx;
  logic         count_en;
  logic         wrap_ok;

  // All arithmetic at N+1 bits so q+step and q+mod_max+1 never truncate.
  logic [N:0] q_ext, step_ext, max_ext, lim_ext, sum_up, wrap_up, wrap_dn;

  assign q_ext    = {1'b0, q};
  assign step_ext = {1'b0, step};
  assign max_ext  = {1'b0, mod_max};
  assign lim_ext  = max_ext + 1'b1;
  assign sum_up   = q_ext + step_ext;
  assign wrap_up  = sum_up - lim_ext;
  assign wrap_dn  = q_ext + lim_ext - step_ext;

  assign count_en = load_b && !en_b && (mode != M_HOLD) && (state == RUN);
  // A step larger than the whole range cannot wrap meaningfully; clip instead.
  assign wrap_ok  = (mode == M_WRAP) && (step_ext <= max_ext);

  always_comb begin
    q_nx     = q;
    ovf_nx   = ovf;
    state_nx = state;
    if (!load_b) begin
      q_nx     = (load_in > mod_max) ? mod_max : load_in;
      ovf_nx   = 1'b0;
      state_nx = RUN;
    end else if (count_en && (step != '0)) begin
      if (q_ext > max_ext) begin
        ovf_nx = 1'b1;
        q_nx   = (up || (mode != M_WRAP)) ? mod_max : '0;
      end else if (up) begin
        if (sum_up <= max_ext) begin
          q_nx = sum_up[N-1:0];
        end else begin
          ovf_nx = 1'b1;
          q_nx   = wrap_ok ? wrap_up[N-1:0] : mod_max;
          if (mode == M_ONE) state_nx = HALT;
        end
      end else begin
        if (step_ext <= q_ext) begin
          q_nx = q - step;
        end else begin
          ovf_nx = 1'b1;
          q_nx   = wrap_ok ? wrap_dn[N-1:0] : '0;
          if (mode == M_ONE) state_nx = HALT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      q     <= '0;
      ovf   <= 1'b0;
      state <= RUN;
    end else begin
      q     <= q_nx;
      ovf   <= ovf_nx;
      state <= state_nx;
    end
  end

  assign done  = (state == HALT);
  assign rco_b = !(!en_b && (mode != M_HOLD) && (state == RUN) &&
                   (up ? (q == mod_max) : (q == '0)));

endmodule

// File: tb/tb_mod_up_down_counter.sv
// tb/tb_mod_up_down_counter.sv - scoreboard bench for mod_up_down_counter
// Driver pushes model expectations; monitor pops and compares each cycle.
module tb_mod_up_down_counter;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0, en_b = 1'b1, load_b = 1'b1, up = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] step = 8'd1, mod_max = 8'd9, load_in = 8'd0;
  logic [7:0] q;
  logic       rco_b, ovf, done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       rco;
    logic [7:0] q;
    logic       ovf;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  int m_q    = 0;
  bit m_ovf  = 0;
  bit m_done = 0;

  mod_up_down_counter #(.N(8)) dut (
    .clk(clk), .rst_b(rst_b), .en_b(en_b), .load_b(load_b), .up(up),
    .mode(mode), .step(step), .mod_max(mod_max), .load_in(load_in),
    .q(q), .rco_b(rco_b), .ovf(ovf), .done(done)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; the model works on plain integers.
  task automatic apply(input bit rst, input bit ld, input bit en, input bit u,
                       input bit [1:0] md, input int st, input int mm, input int li);
    exp_t e;
    int   s;
    @(negedge clk);
    rst_b = rst; load_b = ld; en_b = en; up = u; mode = md;
    step = st[7:0]; mod_max = mm[7:0]; load_in = li[7:0];
    e.rco = !(!en && md != 2'd3 && !m_done && (u ? (m_q == mm) : (m_q == 0)));
    if (!rst) begin
      m_q = 0; m_ovf = 0; m_done = 0;
    end else if (!ld) begin
      m_q = (li > mm) ? mm : li; m_ovf = 0; m_done = 0;
    end else if (!en && md != 2'd3 && !m_done && st != 0) begin
      if (m_q > mm) begin
        m_ovf = 1;
        m_q = (u || md != 2'd0) ? mm : 0;
      end else if (u) begin
        s = m_q + st;
        if (s <= mm) m_q = s;
        else begin
          m_ovf = 1;
          m_q = (md == 2'd0 && st <= mm) ? s - (mm + 1) : mm;
          if (md == 2'd2) m_done = 1;
        end
      end else begin
        if (st <= m_q) m_q = m_q - st;
        else begin
          m_ovf = 1;
          m_q = (md == 2'd0 && st <= mm) ? m_q + mm + 1 - st : 0;
          if (md == 2'd2) m_done = 1;
        end
      end
    end
    e.q = m_q[7:0]; e.ovf = m_ovf; e.done = m_done;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rco_b !== e.rco) begin
          errors++;
          $display("FAIL rco_b at %0t: got %b want %b (q=%0d)", $time, rco_b, e.rco, q);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({q, ovf, done} !== {e.q, e.ovf, e.done}) begin
          errors++;
          $display("FAIL state at %0t: got q=%0d ovf=%b done=%b want q=%0d ovf=%b done=%b",
                   $time, q, ovf, done, e.q, e.ovf, e.done);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int mm, st;
    apply(0, 1, 0, 1, 2'd0, 1, 9, 0);
    // Wrap, mod 10, through the 9->0 boundary.
    for (int i = 0; i < 12; i++) apply(1, 1, 0, 1, 2'd0, 1, 9, 0);
    // Saturating down-count from 10 in steps of 7.
    apply(1, 0, 1, 0, 2'd1, 7, 200, 10);
    for (int i = 0; i < 3; i++) apply(1, 1, 0, 0, 2'd1, 7, 200, 10);
    // One-shot up, then mode change and enables while halted.
    apply(1, 0, 1, 1, 2'd2, 2, 5, 0);
    for (int i = 0; i < 5; i++) apply(1, 1, 0, 1, 2'd2, 2, 5, 0);
    apply(1, 1, 0, 1, 2'd0, 2, 5, 0);
    apply(1, 1, 0, 0, 2'd1, 2, 5, 0);
    apply(1, 0, 1, 1, 2'd2, 2, 5, 1);
    // Load beats count and clamps; reset beats load.
    apply(1, 0, 0, 1, 2'd0, 1, 100, 250);
    apply(0, 0, 0, 1, 2'd0, 1, 100, 250);
    // mod_max lowered below q, then a zero step.
    apply(1, 0, 1, 0, 2'd0, 1, 200, 50);
    apply(1, 1, 0, 0, 2'd0, 1, 20, 50);
    apply(1, 1, 0, 0, 2'd0, 0, 20, 50);
    apply(1, 1, 0, 1, 2'd3, 3, 20, 0);
    // Wrap with a step larger than the range.
    apply(1, 0, 1, 1, 2'd0, 1, 6, 3);
    apply(1, 1, 0, 1, 2'd0, 9, 6, 3);
    apply(1, 1, 0, 0, 2'd0, 9, 6, 3);
    for (int i = 0; i < 3000; i++) begin
      mm = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 15) : $urandom_range(0, 255);
      st = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 5)  : $urandom_range(0, 255);
      apply($urandom_range(0, 40) != 0, $urandom_range(0, 12) != 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), st, mm, $urandom_range(0, 255));
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
